// File: rtl/multi_port_clear_ram.sv
// multi_port_clear_ram: 1-write/N-read synchronous RAM with byte enables, selectable
// read-during-write behaviour and a hardware clear sweep that runs after reset or on request.
module multi_port_clear_ram #(
    parameter int ENTRY_NUM      = 1024,
    parameter int ENTRY_BIT_SIZE = 32,
    parameter int READ_PORT_NUM  = 2,
    parameter int RDW_MODE       = 0,
    parameter logic [ENTRY_BIT_SIZE-1:0] INIT_VALUE = '0,
    localparam int ADDR_BIT = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1,
    localparam int BYTE_NUM = ENTRY_BIT_SIZE / 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    clearReq,
    output logic                                    ready,
    input  logic                                    wEnable,
    input  logic [BYTE_NUM-1:0]                     wByteEnable,
    input  logic [ADDR_BIT-1:0]                     wAddr,
    input  logic [ENTRY_BIT_SIZE-1:0]               wData,
    input  logic [READ_PORT_NUM-1:0]                rEnable,
    input  logic [READ_PORT_NUM*ADDR_BIT-1:0]       rAddr,
    output logic [READ_PORT_NUM*ENTRY_BIT_SIZE-1:0] rData
);
    localparam int W = ENTRY_BIT_SIZE;
    localparam logic [ADDR_BIT-1:0] LAST = ADDR_BIT'(ENTRY_NUM - 1);

    if (ENTRY_BIT_SIZE % 8 != 0) begin : g_bad_width
        $error("ENTRY_BIT_SIZE must be a multiple of 8");
    end
    if (READ_PORT_NUM < 1) begin : g_bad_ports
        $error("READ_PORT_NUM must be at least 1");
    end

    typedef enum logic {CLEAR, READY} state_e;

    state_e                    state_q, state_d;
    logic [ADDR_BIT-1:0]       clear_ptr_q, clear_ptr_d;
    logic [READ_PORT_NUM*W-1:0] rdata_q, rdata_d;
    logic [W-1:0]              mem [ENTRY_NUM];
    logic                      w_in_range, w_do;
    logic [W-1:0]              w_old, w_merged;

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        if (state_q == CLEAR) begin
            state_d     = (clear_ptr_q == LAST) ? READY : CLEAR;
            clear_ptr_d = (clear_ptr_q == LAST) ? '0 : clear_ptr_q + 1'b1;
        end else if (clearReq) begin
            state_d = CLEAR;
        end
    end

    assign ready      = (state_q == READY);
    assign rData      = rdata_q;
    assign w_in_range = int'(wAddr) < ENTRY_NUM;
    assign w_old      = w_in_range ? mem[wAddr] : '0;
    assign w_do       = ready && wEnable && w_in_range;

    for (genvar b = 0; b < BYTE_NUM; b++) begin : g_byte
        assign w_merged[8*b +: 8] = wByteEnable[b] ? wData[8*b +: 8] : w_old[8*b +: 8];
    end

    // Write-first ports bypass the merged word; out-of-range reads return zero.
    for (genvar i = 0; i < READ_PORT_NUM; i++) begin : g_rd
        logic [ADDR_BIT-1:0] ra;
        logic [W-1:0]        word;
        assign ra   = rAddr[i*ADDR_BIT +: ADDR_BIT];
        assign word = (int'(ra) >= ENTRY_NUM) ? '0 :
                      (RDW_MODE != 0 && w_do && wAddr == ra) ? w_merged : mem[ra];
        assign rdata_d[i*W +: W] = (ready && rEnable[i]) ? word : rdata_q[i*W +: W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == CLEAR)
                mem[clear_ptr_q] <= INIT_VALUE;
            else if (w_do)
                mem[wAddr] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= CLEAR;
            clear_ptr_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            rdata_q     <= rdata_d;
        end
    end
endmodule
